// File: rtl/game_pkg.sv
// game_pkg: game state encodings, keypad codes and the door-lock FSM state type.
package game_pkg;
  localparam logic [3:0] ST_TITLE    = 4'd0;
  localparam logic [3:0] ST_STAFF    = 4'd1;
  localparam logic [3:0] ST_STAGE1   = 4'd2;
  localparam logic [3:0] ST_SUCCESS1 = 4'd3;
  localparam logic [3:0] ST_STAGE2   = 4'd4;
  localparam logic [3:0] ST_SUCCESS2 = 4'd5;
  localparam logic [3:0] ST_STAGE3   = 4'd6;
  localparam logic [3:0] ST_SUCCESS3 = 4'd7;
  localparam logic [3:0] ST_FAIL     = 4'd8;
  localparam logic [3:0] KEY_CLEAR   = 4'd10;
  localparam logic [3:0] KEY_ENTER   = 4'd11;
  typedef enum logic [2:0] {IDLE, ENTRY, CHECK, OPEN, LOCKOUT} lock_state_t;
endpackage

// File: rtl/lockout_timer.sv
// lockout_timer: counts 0..CYCLES-1 after start; done is high on the terminal count.
module lockout_timer #(
  parameter int CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic clr,
  output logic done
);
  localparam int W = CYCLES > 1 ? $clog2(CYCLES) : 1;
  logic [W-1:0] cnt;
  logic run;
  assign done = run && cnt == W'(CYCLES - 1);
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      run <= 1'b0;
      cnt <= '0;
    end else if (start) begin
      run <= 1'b1;
      cnt <= '0;
    end else if (run) begin
      run <= !done;
      cnt <= done ? '0 : cnt + 1'b1;
    end
  end
endmodule

// File: rtl/door_lock_ctrl.sv
// door_lock_ctrl: keypad code entry for the STAGE1 door with retry limit and timed lockout.
module door_lock_ctrl
  import game_pkg::*;
#(
  parameter logic [15:0] CODE           = 16'h2048,
  parameter int          MAX_TRIES      = 3,
  parameter int          LOCKOUT_CYCLES = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] state,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       isLocked,
  output logic       door_open_pulse,
  output logic       wrong_pulse,
  output logic [2:0] digit_cnt,
  output logic       lockout
);
  localparam int TW = $clog2(MAX_TRIES + 1);
  lock_state_t fsm, fsm_n;
  logic [15:0] buffer, buffer_n;
  logic [2:0] cnt_n;
  logic [TW-1:0] tries, tries_n, tries_inc;
  logic open_n, wrong_n, done, start, clr;
  assign clr = state != ST_STAGE1;
  assign start = fsm == CHECK && fsm_n == LOCKOUT;
  assign tries_inc = tries == TW'(MAX_TRIES) ? tries : tries + 1'b1;
  lockout_timer #(.CYCLES(LOCKOUT_CYCLES)) u_timer (
    .clk(clk), .rst(rst), .start(start), .clr(clr), .done(done)
  );
  always_comb begin
    fsm_n = fsm;
    buffer_n = buffer;
    cnt_n = digit_cnt;
    tries_n = tries;
    open_n = 1'b0;
    wrong_n = 1'b0;
    if (clr) begin
      fsm_n = IDLE;
      buffer_n = '0;
      cnt_n = '0;
      tries_n = '0;
    end else begin
      case (fsm)
        IDLE: fsm_n = ENTRY;
        ENTRY: if (key_valid) begin
          if (key_code <= 4'd9 && digit_cnt < 3'd4) begin
            buffer_n = {buffer[11:0], key_code};
            cnt_n = digit_cnt + 3'd1;
          end else if (key_code == KEY_CLEAR) begin
            buffer_n = '0;
            cnt_n = '0;
          end else if (key_code == KEY_ENTER && digit_cnt == 3'd4) begin
            fsm_n = CHECK;
          end
        end
        CHECK: if (buffer == CODE) begin
          fsm_n = OPEN;
          open_n = 1'b1;
        end else begin
          wrong_n = 1'b1;
          tries_n = tries_inc;
          buffer_n = '0;
          cnt_n = '0;
          fsm_n = tries_inc == TW'(MAX_TRIES) ? LOCKOUT : ENTRY;
        end
        LOCKOUT: if (done) begin
          fsm_n = ENTRY;
          tries_n = '0;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm <= IDLE;
      buffer <= '0;
      tries <= '0;
      digit_cnt <= '0;
      isLocked <= 1'b1;
      door_open_pulse <= 1'b0;
      wrong_pulse <= 1'b0;
      lockout <= 1'b0;
    end else begin
      fsm <= fsm_n;
      buffer <= buffer_n;
      tries <= tries_n;
      digit_cnt <= cnt_n;
      isLocked <= fsm_n != OPEN;
      door_open_pulse <= open_n;
      wrong_pulse <= wrong_n;
      lockout <= fsm_n == LOCKOUT;
    end
  end
endmodule
